// File: rtl/deferred_writeback_sched.sv
// deferred_writeback_sched
//   Schedules overlapped (deferred) register/flag writeback for the 6502 core. At each
//   instruction boundary the retiring opcode's destination mask and flag sources are captured
//   into a small FIFO, then replayed as one-cycle strobes during T2 of a following instruction
//   (or on the cycle after capture when DEFER=0). One entry retires per commit.
// Ports
//   clk       core clock
//   rst       synchronous active-high reset
//   rdy       CPU RDY; low freezes the scheduler (flush still honoured)
//   T         one-hot timing state
//   sync      instruction boundary (last cycle of retiring opcode)
//   dest_in   destinations written by retiring opcode
//   flag_in   flag sources updated by retiring opcode
//   flush     discard all pending entries
//   src_mask  registers read by the current opcode this cycle
//   wb_en     one-cycle writeback strobes
//   flag_en   one-cycle flag-update strobes
//   fwd_hit   src_mask AND any pending destination
//   pend_cnt  number of valid entries
//   ovf       sticky: a capture was dropped because the queue was full
module deferred_writeback_sched #(
  parameter int unsigned NUM_DEST = 3,
  parameter int unsigned NUM_FLAG = 3,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned T_W      = 7,
  parameter int unsigned T2_IDX   = 1,
  parameter int unsigned DEFER    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic [T_W-1:0]             T,
  input  logic                       sync,
  input  logic [NUM_DEST-1:0]        dest_in,
  input  logic [NUM_FLAG-1:0]        flag_in,
  input  logic                       flush,
  input  logic [NUM_DEST-1:0]        src_mask,
  output logic [NUM_DEST-1:0]        wb_en,
  output logic [NUM_FLAG-1:0]        flag_en,
  output logic [NUM_DEST-1:0]        fwd_hit,
  output logic [$clog2(DEPTH+1)-1:0] pend_cnt,
  output logic                       ovf
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [NUM_DEST-1:0] dest_q [DEPTH];
  logic [NUM_FLAG-1:0] flag_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ovf_q, ovf_d;

  logic                valid_head, full, t2_ok;
  logic                push, push_ok, commit;
  logic [NUM_DEST-1:0] pend_dest;
  logic                unused_t;

  // Only one T bit is consumed; fold the rest so they are visibly accounted for.
  assign unused_t = ^T;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PtrW'(1);
  endfunction

  assign valid_head = (cnt_q != '0);
  assign full       = (32'(cnt_q) == DEPTH);
  assign t2_ok      = (DEFER != 0) ? T[T2_IDX] : 1'b1;

  // With DEFER=0 the head is registered state, so it is always at least one cycle old.
  assign commit  = !rst && !flush && rdy && valid_head && t2_ok;
  assign push    = !rst && !flush && rdy && sync && ((|dest_in) || (|flag_in));
  // A full queue still accepts a push when the head retires in the same cycle.
  assign push_ok = push && (!full || commit);

  always_comb begin
    pend_dest = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      // Slot i is valid when its distance from the read pointer is below the count.
      if (((i + DEPTH - 32'(rd_ptr_q)) % DEPTH) < 32'(cnt_q)) begin
        pend_dest = pend_dest | dest_q[i];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (commit) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push_ok && !commit) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (commit && !push_ok) begin
        cnt_d = cnt_q - CntW'(1);
      end
      if (push && !push_ok) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage needs no reset: slots are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      dest_q[wr_ptr_q] <= dest_in;
      flag_q[wr_ptr_q] <= flag_in;
    end
  end

  assign wb_en    = commit ? dest_q[rd_ptr_q] : '0;
  assign flag_en  = commit ? flag_q[rd_ptr_q] : '0;
  assign fwd_hit  = rst ? '0 : (src_mask & pend_dest);
  assign pend_cnt = cnt_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_deferred_writeback_sched.sv
// Bench for deferred_writeback_sched: directed scenarios with literal expectations, then
// randomized traffic, all checked against a queue-based model every cycle.
module tb_deferred_writeback_sched;

  localparam int DEPTH = 2;
  localparam logic [6:0] TT0 = 7'b0000001;
  localparam logic [6:0] TT2 = 7'b0000010;
  localparam logic [6:0] TT3 = 7'b0000100;

  logic       clk = 1'b0;
  logic       rst, rdy, sync, flush;
  logic [6:0] T;
  logic [2:0] dest_in, flag_in, src_mask;
  logic [2:0] wb_en, flag_en, fwd_hit;
  logic [1:0] pend_cnt;
  logic       ovf;

  deferred_writeback_sched dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .T        (T),
    .sync     (sync),
    .dest_in  (dest_in),
    .flag_in  (flag_in),
    .flush    (flush),
    .src_mask (src_mask),
    .wb_en    (wb_en),
    .flag_en  (flag_en),
    .fwd_hit  (fwd_hit),
    .pend_cnt (pend_cnt),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] d;
    logic [2:0] f;
  } ent_t;

  ent_t mq[$];
  logic m_ovf;
  bit   model_ok;
  bit   exp_commit;
  int   n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic ry, input logic [6:0] t, input logic s,
                       input logic [2:0] d, input logic [2:0] f, input logic fl,
                       input logic [2:0] sm);
    rst = r; rdy = ry; T = t; sync = s; dest_in = d; flag_in = f; flush = fl; src_mask = sm;
  endtask

  // Settle, then compare every output against the model's view of this cycle.
  task automatic step();
    logic [2:0] exp_wb, exp_fl, or_dest;
    #1;
    exp_commit = !rst && !flush && rdy && (mq.size() > 0) && T[1];
    exp_wb = exp_commit ? mq[0].d : 3'b000;
    exp_fl = exp_commit ? mq[0].f : 3'b000;
    or_dest = 3'b000;
    foreach (mq[i]) or_dest |= mq[i].d;
    if (model_ok) begin
      chk("wb_en", 32'(wb_en), 32'(exp_wb));
      chk("flag_en", 32'(flag_en), 32'(exp_fl));
      chk("fwd_hit", 32'(fwd_hit), rst ? 32'd0 : 32'(src_mask & or_dest));
      chk("pend_cnt", 32'(pend_cnt), 32'(mq.size()));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (exp_commit) void'(mq.pop_front());
      if (rdy && sync && ((dest_in | flag_in) != 3'b000)) begin
        if (mq.size() < DEPTH) mq.push_back({dest_in, flag_in});
        else m_ovf = 1'b1;
      end
    end
    model_ok = 1'b1;
    @(negedge clk);
  endtask

  task automatic cyc();
    step();
    tick();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; model_ok = 0; m_ovf = 0; exp_commit = 0;
    // Reset held two cycles while a capture is offered
    drive(1, 1, TT2, 1, 3'b001, 3'b000, 0, 3'b111);
    cyc();
    step();
    chk("rst_wb", 32'(wb_en), 0);
    chk("rst_fwd", 32'(fwd_hit), 0);
    tick();
    drive(0, 1, TT0, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("rst_pend", 32'(pend_cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    tick();

    // Deferred ADC
    drive(0, 1, TT0, 1, 3'b001, 3'b001, 0, 3'b000);
    cyc();
    drive(0, 1, TT2, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("adc_wb", 32'(wb_en), 32'h1);
    chk("adc_flag", 32'(flag_en), 32'h1);
    chk("adc_pend1", 32'(pend_cnt), 1);
    tick();
    drive(0, 1, TT3, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("adc_pend0", 32'(pend_cnt), 0);
    chk("adc_once", 32'(wb_en), 0);
    tick();

    // Back-to-back INX then DEY
    drive(0, 1, TT0, 1, 3'b010, 3'b000, 0, 3'b000);
    cyc();
    drive(0, 1, TT0, 1, 3'b100, 3'b000, 0, 3'b000);
    cyc();
    drive(0, 1, TT0, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("b2b_pend2", 32'(pend_cnt), 2);
    tick();
    drive(0, 1, TT2, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("b2b_first", 32'(wb_en), 32'h2);
    tick();
    drive(0, 1, TT3, 0, 3'b000, 3'b000, 0, 3'b000);
    cyc();
    drive(0, 1, TT2, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("b2b_second", 32'(wb_en), 32'h4);
    tick();

    // Overflow: three captures without T2
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, TT0, 1, 3'(1 << i), 3'b000, 0, 3'b000);
      cyc();
    end
    drive(0, 1, TT0, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_pend", 32'(pend_cnt), 2);
    tick();
    drive(0, 1, TT2, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("ovf_wb1", 32'(wb_en), 32'h1);
    tick();
    step();
    chk("ovf_wb2", 32'(wb_en), 32'h2);
    tick();
    step();
    chk("ovf_third_dropped", 32'(wb_en), 0);
    tick();

    // Stall on RDY
    drive(0, 1, TT0, 1, 3'b001, 3'b000, 0, 3'b000);
    cyc();
    drive(0, 0, TT2, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("stall_wb", 32'(wb_en), 0);
    chk("stall_pend", 32'(pend_cnt), 1);
    tick();
    drive(0, 1, TT2, 0, 3'b000, 3'b000, 0, 3'b000);
    step();
    chk("stall_resume", 32'(wb_en), 32'h1);
    tick();

    // Flush with forwarding
    drive(0, 1, TT0, 1, 3'b001, 3'b000, 0, 3'b000);
    cyc();
    drive(0, 1, TT0, 0, 3'b000, 3'b000, 0, 3'b011);
    step();
    chk("fwd_hit", 32'(fwd_hit), 32'h1);
    tick();
    drive(0, 1, TT2, 1, 3'b010, 3'b000, 1, 3'b000);
    step();
    chk("flush_no_strobe", 32'(wb_en), 0);
    tick();
    drive(0, 1, TT2, 0, 3'b000, 3'b000, 0, 3'b111);
    step();
    chk("flush_pend", 32'(pend_cnt), 0);
    chk("flush_keeps_ovf", 32'(ovf), 1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int idx;
      idx = ($urandom_range(0, 2) == 0) ? 1 : int'($urandom_range(0, 6));
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), 7'(1 << idx),
            ($urandom_range(0, 2) == 0), 3'($urandom), 3'($urandom),
            ($urandom_range(0, 31) == 0), 3'($urandom));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
